// File: rtl/nvme_pcie_pkg.sv
// Shared definitions for the NVMe PCIe control FIFO.
// Contents: the queued-entry layout (field offsets and total width),
// the fixed byte-enable used for doorbell entries, the rnw/cfgop
// encodings, the arbitration priority type, and a helper that packs
// the individual request fields into one flat entry word.
package nvme_pcie_pkg;

    // Entry layout, least significant field first.
    localparam int unsigned E_BE_LSB    = 0;
    localparam int unsigned E_BE_W      = 8;
    localparam int unsigned E_DATAP_LSB = 8;
    localparam int unsigned E_DATAP_W   = 8;
    localparam int unsigned E_DATA_LSB  = 16;
    localparam int unsigned E_DATA_W    = 64;
    localparam int unsigned E_ADDR_LSB  = 80;
    localparam int unsigned E_ADDR_W    = 64;
    localparam int unsigned E_TAG_LSB   = 144;
    localparam int unsigned E_TAG_W     = 6;
    localparam int unsigned E_CFGOP_BIT = 150;
    localparam int unsigned E_RNW_BIT   = 151;
    localparam int unsigned ENTRY_W     = 152;

    localparam logic [7:0] DB_BE = 8'h0F;

    localparam logic RNW_WRITE = 1'b0;
    localparam logic RNW_READ  = 1'b1;
    localparam logic CFGOP_MEM = 1'b0;
    localparam logic CFGOP_CFG = 1'b1;

    typedef enum logic {
        PRI_UC = 1'b0,
        PRI_DB = 1'b1
    } pri_e;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic        rnw,
        input logic        cfgop,
        input logic [5:0]  tag,
        input logic [63:0] addr,
        input logic [63:0] data,
        input logic [7:0]  datap,
        input logic [7:0]  be
    );
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[E_RNW_BIT]                    = rnw;
        e[E_CFGOP_BIT]                  = cfgop;
        e[E_TAG_LSB   +: E_TAG_W]       = tag;
        e[E_ADDR_LSB  +: E_ADDR_W]      = addr;
        e[E_DATA_LSB  +: E_DATA_W]      = data;
        e[E_DATAP_LSB +: E_DATAP_W]     = datap;
        e[E_BE_LSB    +: E_BE_W]        = be;
        return e;
    endfunction

endpackage

// File: rtl/nvme_pcie_ctlff_if.sv
// Handshake/bus bundle for the NVMe PCIe control FIFO.
// Groups the microcontroller request port (uc_ctlff_* / ctlff_uc_ack),
// the doorbell request port (db_ctlff_* / ctlff_db_ack), the requester
// stage port (ctlff_txrq_* / txrq_ctlff_ack) and the sticky parity
// error indication.
//   slave  : view taken by the FIFO itself
//   master : view taken by the surrounding logic / testbench
interface nvme_pcie_ctlff_if;

    logic        uc_ctlff_valid;
    logic        uc_ctlff_rnw;
    logic        uc_ctlff_cfgop;
    logic [5:0]  uc_ctlff_tag;
    logic [63:0] uc_ctlff_addr;
    logic [63:0] uc_ctlff_data;
    logic [7:0]  uc_ctlff_datap;
    logic [7:0]  uc_ctlff_be;
    logic        ctlff_uc_ack;

    logic        db_ctlff_valid;
    logic [63:0] db_ctlff_addr;
    logic [31:0] db_ctlff_data;
    logic        ctlff_db_ack;

    logic        ctlff_txrq_valid;
    logic        ctlff_txrq_rnw;
    logic        ctlff_txrq_cfgop;
    logic [5:0]  ctlff_txrq_tag;
    logic [63:0] ctlff_txrq_addr;
    logic [63:0] ctlff_txrq_data;
    logic [7:0]  ctlff_txrq_datap;
    logic [7:0]  ctlff_txrq_be;
    logic        txrq_ctlff_ack;

    logic        ctlff_perror_ind;

    modport slave (
        input  uc_ctlff_valid, uc_ctlff_rnw, uc_ctlff_cfgop, uc_ctlff_tag,
               uc_ctlff_addr, uc_ctlff_data, uc_ctlff_datap, uc_ctlff_be,
        output ctlff_uc_ack,
        input  db_ctlff_valid, db_ctlff_addr, db_ctlff_data,
        output ctlff_db_ack,
        output ctlff_txrq_valid, ctlff_txrq_rnw, ctlff_txrq_cfgop, ctlff_txrq_tag,
               ctlff_txrq_addr, ctlff_txrq_data, ctlff_txrq_datap, ctlff_txrq_be,
        input  txrq_ctlff_ack,
        output ctlff_perror_ind
    );

    modport master (
        output uc_ctlff_valid, uc_ctlff_rnw, uc_ctlff_cfgop, uc_ctlff_tag,
               uc_ctlff_addr, uc_ctlff_data, uc_ctlff_datap, uc_ctlff_be,
        input  ctlff_uc_ack,
        output db_ctlff_valid, db_ctlff_addr, db_ctlff_data,
        input  ctlff_db_ack,
        input  ctlff_txrq_valid, ctlff_txrq_rnw, ctlff_txrq_cfgop, ctlff_txrq_tag,
               ctlff_txrq_addr, ctlff_txrq_data, ctlff_txrq_datap, ctlff_txrq_be,
        output txrq_ctlff_ack,
        input  ctlff_perror_ind
    );

endinterface

// File: rtl/nvme_pcie_ctlff_pgen.sv
// nvme_pgen: per-group parity generator.
// Produces one parity bit per BITS_PER_PARITY_BIT-wide slice of data_i.
// With ODDPAR=1 each bit is chosen so that slice plus parity bit holds
// an odd number of ones; with ODDPAR=0 even parity is produced.
// Ports:
//   data_i  [WIDTH]                        data to cover
//   par_o   [WIDTH/BITS_PER_PARITY_BIT]    generated parity bits
module nvme_pgen #(
    parameter int unsigned WIDTH               = 64,
    parameter int unsigned BITS_PER_PARITY_BIT = 8,
    parameter bit          ODDPAR              = 1'b1
) (
    input  logic [WIDTH-1:0]                     data_i,
    output logic [WIDTH/BITS_PER_PARITY_BIT-1:0] par_o
);

    localparam int unsigned NPAR = WIDTH / BITS_PER_PARITY_BIT;

    always_comb begin
        par_o = '0;
        for (int unsigned g = 0; g < NPAR; g++) begin
            par_o[g] = (^data_i[g*BITS_PER_PARITY_BIT +: BITS_PER_PARITY_BIT]) ^ ODDPAR;
        end
    end

endmodule

// File: rtl/nvme_pcie_ctlff.sv
// nvme_pcie_ctlff: control request FIFO in front of the PCIe requester.
// Two request sources (microcontroller, queue doorbell) are arbitrated
// round-robin into a DEPTH-entry circular buffer; the head entry is
// presented to the requester stage and popped on its ack.
// Ports:
//   user_clk      sole clock
//   user_reset_n  asynchronous active-low reset
//   bus           nvme_pcie_ctlff_if.slave: both request ports with their
//                 combinational acks, the requester-stage port and the
//                 sticky parity error indication
module nvme_pcie_ctlff
    import nvme_pcie_pkg::*;
#(
    parameter int unsigned DEPTH               = 4,
    parameter int unsigned bits_per_parity_bit = 8
) (
    input  logic                 user_clk,
    input  logic                 user_reset_n,
    nvme_pcie_ctlff_if.slave     bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned NPAR  = 64 / bits_per_parity_bit;

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    pri_e             pri_q, pri_d;
    logic             perror_q, perror_d;

    logic             full, empty;
    logic             uc_win, db_win;
    logic             uc_ack, db_ack;
    logic             push, pop;
    logic [63:0]      db_data64;
    logic [63:0]      par_in;
    logic [NPAR-1:0]  par_out;
    logic [7:0]       gen_par;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Priority only decides when both sources are valid; a lone source wins.
    assign uc_win = bus.uc_ctlff_valid & (~bus.db_ctlff_valid | (pri_q == PRI_UC));
    assign db_win = bus.db_ctlff_valid & ~uc_win;

    // Reset gating keeps both acks low while user_reset_n is held.
    assign uc_ack = uc_win & ~full & user_reset_n;
    assign db_ack = db_win & ~full & user_reset_n;

    assign push = uc_ack | db_ack;
    assign pop  = bus.txrq_ctlff_ack & ~empty;

    assign db_data64 = {32'h0, bus.db_ctlff_data};

    // One parity generator serves both paths: it checks the microcontroller
    // data when that source wins, otherwise it builds the doorbell datap.
    assign par_in = uc_win ? bus.uc_ctlff_data : db_data64;

    nvme_pgen #(
        .WIDTH               (64),
        .BITS_PER_PARITY_BIT (bits_per_parity_bit),
        .ODDPAR              (1'b1)
    ) u_pgen (
        .data_i (par_in),
        .par_o  (par_out)
    );

    assign gen_par = 8'(par_out);

    always_comb begin
        push_entry = '0;
        if (uc_win) begin
            push_entry = pack_entry(bus.uc_ctlff_rnw, bus.uc_ctlff_cfgop, bus.uc_ctlff_tag,
                                    bus.uc_ctlff_addr, bus.uc_ctlff_data,
                                    bus.uc_ctlff_datap, bus.uc_ctlff_be);
        end else begin
            push_entry = pack_entry(RNW_WRITE, CFGOP_MEM, 6'h00, bus.db_ctlff_addr,
                                    db_data64, gen_par, DB_BE);
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pri_d    = pri_q;
        perror_d = perror_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (uc_ack) pri_d = PRI_DB;
        if (db_ack) pri_d = PRI_UC;

        if (uc_ack && (gen_par != bus.uc_ctlff_datap)) perror_d = 1'b1;
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pri_q    <= PRI_UC;
            perror_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pri_q    <= pri_d;
            perror_q <= perror_d;
        end
    end

    // Storage needs no reset: occupancy gates everything that is presented.
    always_ff @(posedge user_clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    // Head fields read as zero whenever nothing valid is queued (incl. reset).
    assign head = empty ? '0 : mem_q[rd_ptr_q];

    assign bus.ctlff_uc_ack     = uc_ack;
    assign bus.ctlff_db_ack     = db_ack;
    assign bus.ctlff_txrq_valid = ~empty;
    assign bus.ctlff_txrq_rnw   = head[E_RNW_BIT];
    assign bus.ctlff_txrq_cfgop = head[E_CFGOP_BIT];
    assign bus.ctlff_txrq_tag   = head[E_TAG_LSB   +: E_TAG_W];
    assign bus.ctlff_txrq_addr  = head[E_ADDR_LSB  +: E_ADDR_W];
    assign bus.ctlff_txrq_data  = head[E_DATA_LSB  +: E_DATA_W];
    assign bus.ctlff_txrq_datap = head[E_DATAP_LSB +: E_DATAP_W];
    assign bus.ctlff_txrq_be    = head[E_BE_LSB    +: E_BE_W];
    assign bus.ctlff_perror_ind = perror_q;

endmodule
